pipelined_shifter: RTL

- Parametrised, pipelined barrel shifter for the RV32 pipeline's ALU/EX path.
- Replaces the single-cycle shift unit. It generalises operand width and pipeline depth, and adds a valid/ready handshake, a pass-through tag and a flush.
- Serves the SLL/SRL/SRA and SLLI/SRLI/SRAI instructions. The EX-stage control holds dependent instructions on out_valid.

---
 rtl/pipelined_shifter_pkg.sv | 33 +++
 rtl/pipelined_shifter_stage.sv | 138 +++++++++++++
 rtl/pipelined_shifter.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipelined_shifter_pkg.sv
// ============================================================================
//  Module      : pipelined_shifter_pkg
//  Description : Shared constants and helpers for the pipelined barrel shifter.
//                Holds the shift-type encoding and the function that splits
//                the shift levels across the pipeline stages.
//  Config      : none (SHIFTER_ROTATE_EN is consumed by the stage module)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipelined_shifter_pkg;

    // Shift-type encoding carried on in_type
    localparam int          SHIFT_TYPE_W = 2;
    localparam logic [1:0]  SHIFT_SLL    = 2'b00;  // zero fill from the right
    localparam logic [1:0]  SHIFT_SRL    = 2'b01;  // zero fill from the left
    localparam logic [1:0]  SHIFT_SRA    = 2'b10;  // fill with the operand sign
    localparam logic [1:0]  SHIFT_ROR    = 2'b11;  // rotate right / reserved

    typedef logic [SHIFT_TYPE_W-1:0] shift_type_t;

    // First shift level owned by a stage. Stage s covers levels
    // [level_split(s), level_split(s+1)-1]; level_split(STAGES) == levels.
    // Integer division spreads the levels as evenly as possible, with the
    // later stages taking the extra level when they do not divide evenly.
    function automatic int level_split(input int stage, input int levels,
                                       input int stages);
        return (stage * levels) / stages;
    endfunction

endpackage : pipelined_shifter_pkg

`default_nettype wire

// File: rtl/pipelined_shifter_stage.sv
// ============================================================================
//  Module      : pipelined_shifter_stage
//  Description : One register stage of the pipelined barrel shifter. Applies
//                shift levels LO_LEVEL..HI_LEVEL (level k shifts by 2^k when
//                shamt[k] is set) and registers the partial result together
//                with the side-band fields needed by the later stages.
//  Config      : SHIFTER_ROTATE_EN - when defined, type 2'b11 rotates right;
//                when undefined, type 2'b11 forces the data to zero and no
//                rotate muxing exists.
//  Ports       : clk, rst_n        clock, async active-low reset
//                en_i              pipeline advance (global stall when 0)
//                flush_i           kill the valid bit at the next edge
//                valid_i/_o        stage occupancy
//                data_i/_o         partial result
//                shamt_i/_o        full shift amount (later stages use
//                                  the upper bits)
//                type_i/_o         shift type
//                sign_i/_o         sign of the original operand
//                tag_i/_o          opaque tag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_shifter_stage
    import pipelined_shifter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LO_LEVEL = 0,
    parameter int HI_LEVEL = 0,
    parameter int TAG_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic [XLEN-1:0]           data_i,
    input  logic [$clog2(XLEN)-1:0]   shamt_i,
    input  logic [SHIFT_TYPE_W-1:0]   type_i,
    input  logic                      sign_i,
    input  logic [TAG_W-1:0]          tag_i,
    output logic                      valid_o,
    output logic [XLEN-1:0]           data_o,
    output logic [$clog2(XLEN)-1:0]   shamt_o,
    output logic [SHIFT_TYPE_W-1:0]   type_o,
    output logic                      sign_o,
    output logic [TAG_W-1:0]          tag_o
);

    localparam int SHW = $clog2(XLEN);

    logic                    valid_q;
    logic [XLEN-1:0]         data_q;
    logic [XLEN-1:0]         data_d;
    logic [SHW-1:0]          shamt_q;
    logic [SHIFT_TYPE_W-1:0] type_q;
    logic                    sign_q;
    logic [TAG_W-1:0]        tag_q;

    // ------------------------------------------------------------------
    // Level muxes for this stage's slice of the shift amount. Shifts by
    // distinct powers of two compose additively, so applying the levels
    // one after another over successive stages gives the full shift.
    // ------------------------------------------------------------------
    always_comb begin
        logic [SHW-1:0] sh_bits;
        int             amt;
        data_d = data_i;
        for (int k = LO_LEVEL; k <= HI_LEVEL; k++) begin
            amt     = 1 << k;
            sh_bits = shamt_i >> k;
            if (sh_bits[0]) begin
                case (type_i)
                    SHIFT_SLL: data_d = data_d << amt;
                    SHIFT_SRL: data_d = data_d >> amt;
                    // Arithmetic shift: fill the vacated top bits with the
                    // sign of the original operand, which travels with the
                    // request so every stage sees the same fill value.
                    SHIFT_SRA: data_d = (data_d >> amt)
                                      | ({XLEN{sign_i}} & ~({XLEN{1'b1}} >> amt));
                    default: begin
`ifdef SHIFTER_ROTATE_EN
                        data_d = (data_d >> amt) | (data_d << (XLEN - amt));
`else
                        data_d = data_d;
`endif
                    end
                endcase
            end
        end
`ifdef SHIFTER_ROTATE_EN
        // Type 2'b11 handled by the rotate levels above.
`else
        // Reserved type: result is zero regardless of the shift amount.
        if (type_i == SHIFT_ROR) begin
            data_d = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Stage register. Flush only has to clear the valid bit; the data
    // fields of a killed entry are never observed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (en_i) begin
                valid_q <= valid_i;
            end
            if (en_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                type_q  <= type_i;
                sign_q  <= sign_i;
                tag_q   <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign type_o  = type_q;
    assign sign_o  = sign_q;
    assign tag_o   = tag_q;

endmodule : pipelined_shifter_stage

`default_nettype wire

// File: rtl/pipelined_shifter.sv
// ============================================================================
//  Module      : pipelined_shifter
//  Description : Parametrised pipelined barrel shifter (SLL/SRL/SRA, optional
//                ROR) with valid/ready handshake, pass-through tag and flush.
//                A request accepted in cycle N is presented in cycle
//                N+STAGES when the consumer is not stalling.
//  Config      : SHIFTER_ROTATE_EN - enables rotate-right on type 2'b11;
//                otherwise type 2'b11 yields a zero result.
//  Parameters  : XLEN   operand width, power of two, 8..64
//                STAGES register stages, 1..$clog2(XLEN)
//                TAG_W  width of the opaque tag
//  Ports       : clk, rst_n          clock, async active-low reset
//                flush               kill all in-flight requests
//                in_valid/in_ready   request handshake
//                in_a, in_shamt      operand, shift amount (mod XLEN)
//                in_type, in_tag     shift type, opaque tag
//                out_valid/out_ready result handshake
//                out_result, out_tag shifted value and its tag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_a,
    input  logic [$clog2(XLEN)-1:0]   in_shamt,
    input  logic [SHIFT_TYPE_W-1:0]   in_type,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_result,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int SHW = $clog2(XLEN);

    // Element s feeds stage s; element STAGES is the output register.
    logic                    w_valid [0:STAGES];
    logic [XLEN-1:0]         w_data  [0:STAGES];
    logic [SHW-1:0]          w_shamt [0:STAGES];
    logic [SHIFT_TYPE_W-1:0] w_type  [0:STAGES];
    logic                    w_sign  [0:STAGES];
    logic [TAG_W-1:0]        w_tag   [0:STAGES];

    logic                    w_advance;

    // Single global stall: the whole pipe moves when the output slot is
    // empty or being drained. Bubbles are deliberately not compressed,
    // which keeps the enable a single fan-out net.
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    // An un-accepted request can only appear while in_ready is 0, and then
    // stage 0 is not enabled, so in_valid can feed stage 0 directly.
    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_a;
    assign w_shamt[0] = in_shamt;
    assign w_type[0]  = in_type;
    assign w_sign[0]  = in_a[XLEN-1];
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = level_split(s,     SHW, STAGES);
        localparam int HI = level_split(s + 1, SHW, STAGES) - 1;

        pipelined_shifter_stage #(
            .XLEN     (XLEN),
            .LO_LEVEL (LO),
            .HI_LEVEL (HI),
            .TAG_W    (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (w_advance),
            .flush_i (flush),
            .valid_i (w_valid[s]),
            .data_i  (w_data[s]),
            .shamt_i (w_shamt[s]),
            .type_i  (w_type[s]),
            .sign_i  (w_sign[s]),
            .tag_i   (w_tag[s]),
            .valid_o (w_valid[s+1]),
            .data_o  (w_data[s+1]),
            .shamt_o (w_shamt[s+1]),
            .type_o  (w_type[s+1]),
            .sign_o  (w_sign[s+1]),
            .tag_o   (w_tag[s+1])
        );
    end

    assign out_valid  = w_valid[STAGES];
    assign out_result = w_data[STAGES];
    assign out_tag    = w_tag[STAGES];

    // The last stage's side-band copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{w_shamt[STAGES], w_type[STAGES], w_sign[STAGES]};

endmodule : pipelined_shifter

`default_nettype wire
